// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer: drives one shared 16-bit adder over WORDS slices to add/subtract N-bit operands
module multiword_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*WORDS-1:0] A,
  input  logic [16*WORDS-1:0] B,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*WORDS-1:0] Sum,
  output logic                Cout,
  output logic                Ovf,
  output logic                busy,
  output logic [15:0]         add_A,
  output logic [15:0]         add_B,
  output logic                add_cin,
  input  logic [15:0]         add_S,
  input  logic                add_cout
);
  localparam int N  = 16 * WORDS;
  localparam int IW = $clog2(WORDS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q;
  logic            carry_q;
  logic [N-1:0]    a_q, bx_q, sum_q;
  logic            cout_q, ovf_q;
  logic            run, last;
  assign run  = state_q == RUN;
  assign last = idx_q == IW'(WORDS - 1);
  // state register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end
  // next-state: accept in IDLE, walk the slices in RUN, hold the result in DONE until taken
  always_comb begin
    state_d = (state_q == IDLE) ? (in_valid ? RUN : IDLE) :
              (state_q == RUN)  ? (last ? DONE : RUN) :
                                  (out_ready ? IDLE : DONE);
  end
  // outputs: handshake flags and the adder feed, which is zero outside RUN
  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
    busy      = run;
    add_A     = run ? a_q[{idx_q, 4'b0} +: 16] : 16'd0;
    add_B     = run ? bx_q[{idx_q, 4'b0} +: 16] : 16'd0;
    add_cin   = run & carry_q;
  end
  // datapath: capture operands on accept, store one result slice per RUN cycle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      bx_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q == IDLE && in_valid) begin
      a_q     <= A;
      bx_q    <= sub ? ~B : B;
      carry_q <= sub;
      idx_q   <= '0;
    end else if (run) begin
      sum_q[{idx_q, 4'b0} +: 16] <= add_S;
      carry_q <= add_cout;
      idx_q   <= last ? '0 : idx_q + IW'(1);
      if (last) begin
        cout_q <= add_cout;
        ovf_q  <= (a_q[N-1] == bx_q[N-1]) & (add_S[15] != a_q[N-1]);
      end
    end
  end
  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb_multiword_add_sequencer: vector table, corner sequences and random ops against an arithmetic model
module tb_multiword_add_sequencer;
  localparam int WORDS = 4;
  localparam int N = 16 * WORDS;
  logic         Clk = 0, Reset = 1, in_valid = 0, sub = 0, out_ready = 0;
  logic [N-1:0] A = '0, B = '0;
  logic         in_ready, out_valid, Cout, Ovf, busy, add_cin, add_cout;
  logic [N-1:0] Sum;
  logic [15:0]  add_A, add_B, add_S;
  int n_cmp = 0, n_bad = 0;
  logic cin_log[$];

  multiword_add_sequencer #(.WORDS(WORDS)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Cout(Cout), .Ovf(Ovf), .busy(busy),
    .add_A(add_A), .add_B(add_B), .add_cin(add_cin),
    .add_S(add_S), .add_cout(add_cout)
  );

  always #5 Clk = ~Clk;
  assign {add_cout, add_S} = {1'b0, add_A} + {1'b0, add_B} + {16'd0, add_cin};
  always @(negedge Clk) if (busy) cin_log.push_back(add_cin);

  typedef struct {
    logic [N-1:0] a, b;
    logic         s;
    logic [N-1:0] sum;
    logic         cout, ovf;
  } vec_t;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [N-1:0] a, b, input logic s,
                                output logic [N-1:0] sm, output logic co, ov);
    logic signed [N+1:0] sa, sb, r;
    sa = $signed({{2{a[N-1]}}, a});
    sb = $signed({{2{b[N-1]}}, b});
    r  = s ? sa - sb : sa + sb;
    sm = r[N-1:0];
    co = s ? (a >= b) : ({1'b0, a} + {1'b0, b}) >> N != 0;
    ov = r > $signed({3'b0, {(N-1){1'b1}}}) || r < -$signed({2'b0, 1'b1, {(N-1){1'b0}}});
  endfunction

  task automatic do_op(input logic [N-1:0] a, b, input logic s,
                       output logic [N-1:0] sm, output logic co, ov, output int lat);
    int t = 0;
    @(negedge Clk);
    A = a; B = b; sub = s; in_valid = 1; out_ready = 0;
    while (!in_ready && t < 50) begin @(negedge Clk); t++; end
    chk("accept_ready", {63'd0, in_ready}, 64'd1);
    @(posedge Clk); #1 in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge Clk); #1; lat++; end
    sm = Sum; co = Cout; ov = Ovf;
    @(negedge Clk); out_ready = 1;
    @(posedge Clk); #1 out_ready = 0;
  endtask

  task automatic run_check(input string tag, input logic [N-1:0] a, b, input logic s,
                           input logic [N-1:0] esum, input logic ecout, eovf);
    logic [N-1:0] sm; logic co, ov; int lat;
    do_op(a, b, s, sm, co, ov, lat);
    chk({tag, "_sum"}, sm, esum);
    chk({tag, "_cout"}, {63'd0, co}, {63'd0, ecout});
    chk({tag, "_ovf"}, {63'd0, ov}, {63'd0, eovf});
    chk({tag, "_lat"}, 64'(lat), 64'(WORDS));
  endtask

  initial begin
    vec_t vt[6];
    logic [N-1:0] es, es2, sm; logic ec, eo, co, ov; int lat, t;
    vt[0] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vt[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0};
    vt[2] = '{64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vt[3] = '{64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0};
    vt[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vt[5] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};

    repeat (2) @(posedge Clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sum", Sum, 64'd0);
    chk("rst_cout_ovf_busy", {61'd0, Cout, Ovf, busy}, 64'd0);
    chk("rst_add_bus", {31'd0, add_A, add_B, add_cin}, 64'd0);
    @(negedge Clk); Reset = 0;

    for (int i = 0; i < 6; i++)
      run_check($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].s, vt[i].sum, vt[i].cout, vt[i].ovf);

    // carry ripple through every slice: cin per RUN cycle must be 0,1,1,1
    cin_log.delete();
    run_check("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0);
    chk("ripple_cin_count", 64'(cin_log.size()), 64'd4);
    if (cin_log.size() == 4)
      chk("ripple_cin_seq", {60'd0, cin_log[0], cin_log[1], cin_log[2], cin_log[3]}, 64'b0111);

    // backpressure: result held while out_ready is low and a new request waits
    model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, es, ec, eo);
    model(64'h0000_0001_0000_0000, 64'd3, 1'b1, es2, ec, eo);
    @(negedge Clk);
    A = 64'h1234_5678_9ABC_DEF0; B = 64'h0FED_CBA9_8765_4321; sub = 0; in_valid = 1;
    @(posedge Clk); #1 in_valid = 0;
    t = 0;
    while (!out_valid && t < 50) begin @(posedge Clk); #1; t++; end
    chk("bp_lat", 64'(t), 64'(WORDS));
    @(negedge Clk);
    A = 64'h0000_0001_0000_0000; B = 64'd3; sub = 1; in_valid = 1; out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_hold_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_hold_sum", Sum, es);
    end
    @(negedge Clk); out_ready = 1;
    @(posedge Clk); #1;
    chk("bp_release_valid", {63'd0, out_valid}, 64'd0);
    chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 0;
    @(posedge Clk); #1 in_valid = 0;
    chk("bp_second_busy", {63'd0, busy}, 64'd1);
    t = 0;
    while (!out_valid && t < 50) begin @(posedge Clk); #1; t++; end
    chk("bp_second_sum", Sum, es2);
    chk("bp_second_cout", {63'd0, Cout}, 64'd1);
    @(negedge Clk); out_ready = 1;
    @(posedge Clk); #1 out_ready = 0;

    // reset in the middle of RUN discards the partial operation
    @(negedge Clk);
    A = 64'hFFFF_FFFF_FFFF_FFFF; B = 64'hFFFF_FFFF_FFFF_FFFF; sub = 0; in_valid = 1;
    @(posedge Clk); #1 in_valid = 0;
    repeat (2) @(posedge Clk);
    @(negedge Clk); Reset = 1;
    @(posedge Clk); #1;
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_sum", Sum, 64'd0);
    chk("midrst_add_bus", {31'd0, add_A, add_B, add_cin}, 64'd0);
    @(negedge Clk); Reset = 0;
    run_check("post_rst", 64'd1, 64'd1, 1'b0, 64'd2, 1'b0, 1'b0);

    // random operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] ra, rb; logic rs;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      if (i % 8 == 1) rb = ra;
      if (i % 8 == 2) ra[15:0] = 16'hFFFF;
      if (i % 8 == 3) ra[N-1] = ~rb[N-1] ^ rs;
      model(ra, rb, rs, es, ec, eo);
      run_check($sformatf("rnd%0d", i), ra, rb, rs, es, ec, eo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
